mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pick.sv | 66 ++++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the two-port memory arbiter.
// Holds the FSM state encoding, the requester port index type and a
// one-hot to index helper used by both the top and the winner picker.
`timescale 1ns/1ps

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Port 0 is the CPU, port 1 is the debug/loader master.
  typedef logic port_idx_t;

  localparam port_idx_t PORT_CPU = 1'b0;
  localparam port_idx_t PORT_DBG = 1'b1;

  // Only ever called with a one-hot (or zero) vector; port 1 maps to index 1.
  function automatic port_idx_t oh_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: selects one winner among the two requesters.
// Build option MEM_ARB_RR_EN: when defined, contention resolves round-robin
// (the port not granted last wins) and a last-grant register is kept here,
// reset to port 1 so port 0 wins first. When undefined, port 0 always wins
// and no last-grant state exists.
`timescale 1ns/1ps

module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt_oh
);

`ifdef MEM_ARB_RR_EN
  port_idx_t last_q;
  port_idx_t last_d;

  // Remember which port was granted whenever the arbiter accepts a request.
  always_comb begin
    last_d = last_q;
    if (take) begin
      last_d = oh_to_idx(gnt_oh);
    end
  end

  // Last-grant register, only advanced on enabled edges.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBG;
    end else if (clk_en) begin
      last_q <= last_d;
    end
  end

  // Round-robin pick: on contention favour the port not granted last.
  always_comb begin
    gnt_oh = 2'b00;
    case (req)
      2'b01:   gnt_oh = 2'b01;
      2'b10:   gnt_oh = 2'b10;
      2'b11:   gnt_oh = (last_q == PORT_CPU) ? 2'b10 : 2'b01;
      default: gnt_oh = 2'b00;
    endcase
  end
`else
  // Fixed priority needs no history, so the clocking inputs go unused.
  logic unused_rr;
  assign unused_rr = ^{clk_100M, rst_n, clk_en, take};

  // Fixed priority pick: port 0 always wins contention.
  always_comb begin
    gnt_oh = 2'b00;
    if (req[0]) begin
      gnt_oh = 2'b01;
    end else if (req[1]) begin
      gnt_oh = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port synchronous RAM.
// Port 0 is the CPU, port 1 the debug/loader. One transaction is in flight
// at a time; a read returns data two enabled cycles after its grant, a write
// hits the RAM one enabled cycle after its grant. All state advances only on
// clk_100M edges with clk_en high.
// Build option MEM_ARB_RR_EN selects round-robin contention in mem_arb_pick;
// without it port 0 has fixed priority.
//
// state  | meaning
// IDLE   | no transaction; grant the picked requester and latch its command
// ACCESS | latched command driven to RAM; writes finish here
// RESP   | RAM read data returned to the winner with a one-cycle rvalid
`timescale 1ns/1ps

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic              clk_en,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,

  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  port_idx_t         win_q, win_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        req_vec;
  logic [1:0]        pick_oh;
  logic              take;

  assign req_vec = {req1, req0};
  assign take    = (state_q == IDLE) && (|req_vec);

  mem_arb_pick u_pick (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .req      (req_vec),
    .take     (take),
    .gnt_oh   (pick_oh)
  );

  // Next-state, command latch and per-port response pulses.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    win_d    = win_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;

    case (state_q)
      IDLE: begin
        if (take) begin
          gnt0  = pick_oh[0];
          gnt1  = pick_oh[1];
          win_d = oh_to_idx(pick_oh);
          if (pick_oh[1]) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
          end
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        state_d = we_q ? IDLE : RESP;
      end

      RESP: begin
        // RAM data is valid in this cycle; pass it through and keep a copy.
        if (win_q == PORT_CPU) begin
          rvalid0  = 1'b1;
          rdata0_d = mem_r_data;
        end else begin
          rvalid1  = 1'b1;
          rdata1_d = mem_r_data;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers; held whenever clk_en is low.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      win_q    <= PORT_CPU;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      win_q    <= win_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Write enable is derived from state so reset removes it immediately.
  assign mem_wr_en  = (state_q == ACCESS) && we_q;
  assign mem_addr   = addr_q;
  assign mem_w_data = wdata_q;
  assign busy       = (state_q != IDLE);

  // Read data shows in the RESP cycle itself, then holds the captured copy.
  assign rdata0 = rdata0_d;
  assign rdata1 = rdata1_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for the basic
// read/write/wait flows, then hand sequences for contention, clock-enable
// freeze and reset during a write.
`timescale 1ns/1ps

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clk_en   = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_w_data;
  logic [31:0] mem_r_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_100M = ~clk_100M;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_100M   (clk_100M),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .gnt0       (gnt0),
    .rvalid0    (rvalid0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .gnt1       (gnt1),
    .rvalid1    (rvalid1),
    .rdata1     (rdata1),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data),
    .busy       (busy)
  );

  // Synchronous RAM model, qualified by clk_en like the arbiter.
  logic [31:0] ram [0:255];
  logic        preloaded = 1'b0;
  int          wr_count  = 0;

  always @(posedge clk_100M) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram[0]    <= 32'h2008_0005;
      ram[8]    <= 32'h1234_5678;
      preloaded <= 1'b1;
    end else if (clk_en) begin
      if (mem_wr_en) begin
        ram[mem_addr[9:2]] <= mem_w_data;
        wr_count <= wr_count + 1;
      end
      mem_r_data <= ram[mem_addr[9:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        gnt0, gnt1, wr, busy, rv0, rv1;
    logic [31:0] maddr, wdat, rd0, rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic wr, input logic bz,
    input logic v0, input logic v1,
    input logic [31:0] ma, input logic [31:0] wd, input logic [31:0] q0, input logic [31:0] q1);
    vec_t v;
    v.req0 = r0; v.we0 = w0; v.addr0 = a0; v.wdata0 = d0;
    v.req1 = r1; v.we1 = w1; v.addr1 = a1; v.wdata1 = d1;
    v.gnt0 = g0; v.gnt1 = g1; v.wr = wr; v.busy = bz; v.rv0 = v0; v.rv1 = v1;
    v.maddr = ma; v.wdat = wd; v.rd0 = q0; v.rd1 = q1;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    logic [1:0]  g;
    logic [1:0]  exp_g;
    logic        got;
    int          wc0;

    vecs[0]  = mk(0,0,32'h0,0,          0,0,0,0,                     0,0,0,0,0,0, 32'h0,        0, 32'h0,         32'h0);
    vecs[1]  = mk(1,0,32'h0040_0000,0,  0,0,0,0,                     1,0,0,0,0,0, 32'h0,        0, 32'h0,         32'h0);
    vecs[2]  = mk(0,0,0,0,              0,0,0,0,                     0,0,0,1,0,0, 32'h0040_0000,0, 32'h0,         32'h0);
    vecs[3]  = mk(0,0,0,0,              0,0,0,0,                     0,0,0,1,1,0, 32'h0040_0000,0, 32'h2008_0005, 32'h0);
    vecs[4]  = mk(0,0,0,0,              0,0,0,0,                     0,0,0,0,0,0, 32'h0040_0000,0, 32'h2008_0005, 32'h0);
    vecs[5]  = mk(0,0,0,0,              1,1,32'h10,32'hDEAD_BEEF,    0,1,0,0,0,0, 32'h0040_0000,0, 32'h2008_0005, 32'h0);
    vecs[6]  = mk(0,0,0,0,              0,0,0,0,                     0,0,1,1,0,0, 32'h10, 32'hDEAD_BEEF, 32'h2008_0005, 32'h0);
    vecs[7]  = mk(1,0,32'h10,0,         0,0,0,0,                     1,0,0,0,0,0, 32'h10,       0, 32'h2008_0005, 32'h0);
    vecs[8]  = mk(0,0,0,0,              0,0,0,0,                     0,0,0,1,0,0, 32'h10,       0, 32'h2008_0005, 32'h0);
    vecs[9]  = mk(0,0,0,0,              0,0,0,0,                     0,0,0,1,1,0, 32'h10,       0, 32'hDEAD_BEEF, 32'h0);
    vecs[10] = mk(0,0,0,0,              0,0,0,0,                     0,0,0,0,0,0, 32'h10,       0, 32'hDEAD_BEEF, 32'h0);
    vecs[11] = mk(1,0,32'h20,0,         0,0,0,0,                     1,0,0,0,0,0, 32'h10,       0, 32'hDEAD_BEEF, 32'h0);
    vecs[12] = mk(0,0,0,0,              1,0,32'h0040_0000,0,         0,0,0,1,0,0, 32'h20,       0, 32'hDEAD_BEEF, 32'h0);
    vecs[13] = mk(0,0,0,0,              1,0,32'h0040_0000,0,         0,0,0,1,1,0, 32'h20,       0, 32'h1234_5678, 32'h0);
    vecs[14] = mk(0,0,0,0,              1,0,32'h0040_0000,0,         0,1,0,0,0,0, 32'h20,       0, 32'h1234_5678, 32'h0);
    vecs[15] = mk(0,0,0,0,              0,0,0,0,                     0,0,0,1,0,0, 32'h0040_0000,0, 32'h1234_5678, 32'h0);
    vecs[16] = mk(0,0,0,0,              0,0,0,0,                     0,0,0,1,0,1, 32'h0040_0000,0, 32'h1234_5678, 32'h2008_0005);
    vecs[17] = mk(0,0,0,0,              0,0,0,0,                     0,0,0,0,0,0, 32'h0040_0000,0, 32'h1234_5678, 32'h2008_0005);

    // Reset state
    repeat (3) @(negedge clk_100M);
    #1;
    chk("rst gnt0",       32'(gnt0),      32'h0);
    chk("rst gnt1",       32'(gnt1),      32'h0);
    chk("rst mem_wr_en",  32'(mem_wr_en), 32'h0);
    chk("rst busy",       32'(busy),      32'h0);
    chk("rst rvalid",     32'({rvalid1, rvalid0}), 32'h0);
    chk("rst mem_addr",   mem_addr,       32'h0);
    chk("rst mem_w_data", mem_w_data,     32'h0);
    chk("rst rdata0",     rdata0,         32'h0);
    chk("rst rdata1",     rdata1,         32'h0);
    rst_n = 1'b1;

    // Table-driven per-cycle vectors
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_100M);
      req0 = vecs[i].req0; we0 = vecs[i].we0; addr0 = vecs[i].addr0; wdata0 = vecs[i].wdata0;
      req1 = vecs[i].req1; we1 = vecs[i].we1; addr1 = vecs[i].addr1; wdata1 = vecs[i].wdata1;
      #1;
      chk($sformatf("v%0d gnt0", i),     32'(gnt0),      32'(vecs[i].gnt0));
      chk($sformatf("v%0d gnt1", i),     32'(gnt1),      32'(vecs[i].gnt1));
      chk($sformatf("v%0d mem_wr_en", i),32'(mem_wr_en), 32'(vecs[i].wr));
      chk($sformatf("v%0d busy", i),     32'(busy),      32'(vecs[i].busy));
      chk($sformatf("v%0d rvalid0", i),  32'(rvalid0),   32'(vecs[i].rv0));
      chk($sformatf("v%0d rvalid1", i),  32'(rvalid1),   32'(vecs[i].rv1));
      chk($sformatf("v%0d mem_addr", i), mem_addr,       vecs[i].maddr);
      chk($sformatf("v%0d rdata0", i),   rdata0,         vecs[i].rd0);
      chk($sformatf("v%0d rdata1", i),   rdata1,         vecs[i].rd1);
      if (vecs[i].wr) chk($sformatf("v%0d mem_w_data", i), mem_w_data, vecs[i].wdat);
    end
    chk("ram[0x10] after write", ram[4], 32'hDEAD_BEEF);

    // Contention: both ports hold requests across four transactions
    @(negedge clk_100M);
    rst_n = 1'b0;
    @(negedge clk_100M);
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0040_0000;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0;
      g   = 2'b00;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk_100M);
        #1;
        if (gnt0 || gnt1) begin
          got = 1'b1;
          g   = {gnt1, gnt0};
        end
      end
`ifdef MEM_ARB_RR_EN
      exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      if (!got) begin
        n_vec++;
        n_err++;
        $display("FAIL contention t%0d: no grant within 8 cycles, expected grant 0b%02b", t, exp_g);
      end else begin
        chk($sformatf("contention t%0d grant", t), 32'(g), 32'(exp_g));
      end
    end
    @(posedge clk_100M);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk_100M);

    // clk_en low for 3 cycles during ACCESS of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hCAFE_F00D;
    #1;
    chk("frz wr gnt0", 32'(gnt0), 32'h1);
    wc0 = wr_count;
    @(negedge clk_100M);
    req0 = 1'b0; we0 = 1'b0;
    #1;
    chk("frz wr mem_wr_en", 32'(mem_wr_en), 32'h1);
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100M);
      #1;
      chk($sformatf("frz wr hold%0d mem_wr_en", k), 32'(mem_wr_en), 32'h1);
      chk($sformatf("frz wr hold%0d mem_addr", k),  mem_addr,       32'h40);
      chk($sformatf("frz wr hold%0d mem_w_data", k),mem_w_data,     32'hCAFE_F00D);
    end
    clk_en = 1'b1;
    @(negedge clk_100M);
    #1;
    chk("frz wr done mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("frz wr done busy",      32'(busy),      32'h0);
    chk("frz wr write count",    32'(wr_count - wc0), 32'h1);
    chk("frz wr ram[0x40]",      ram[16],        32'hCAFE_F00D);

    // clk_en low for 3 cycles during ACCESS of a read
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    #1;
    chk("frz rd gnt0", 32'(gnt0), 32'h1);
    @(negedge clk_100M);
    req0 = 1'b0;
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100M);
      #1;
      chk($sformatf("frz rd hold%0d rvalid0", k), 32'(rvalid0), 32'h0);
      chk($sformatf("frz rd hold%0d busy", k),    32'(busy),    32'h1);
    end
    clk_en = 1'b1;
    @(negedge clk_100M);
    #1;
    chk("frz rd rvalid0", 32'(rvalid0), 32'h1);
    chk("frz rd rdata0",  rdata0,       32'hCAFE_F00D);
    @(negedge clk_100M);
    #1;
    chk("frz rd rvalid0 drop", 32'(rvalid0), 32'h0);
    chk("frz rd rdata0 hold",  rdata0,       32'hCAFE_F00D);

    // Reset asserted during ACCESS of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h80; wdata0 = 32'h55AA_55AA;
    #1;
    chk("rstw gnt0", 32'(gnt0), 32'h1);
    @(negedge clk_100M);
    req0 = 1'b0; we0 = 1'b0;
    #1;
    chk("rstw mem_wr_en before", 32'(mem_wr_en), 32'h1);
    wc0 = wr_count;
    rst_n = 1'b0;
    #1;
    chk("rstw mem_wr_en",  32'(mem_wr_en), 32'h0);
    chk("rstw busy",       32'(busy),      32'h0);
    chk("rstw mem_addr",   mem_addr,       32'h0);
    chk("rstw rdata0",     rdata0,         32'h0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0040_0000;
    #1;
    chk("rstw first gnt0", 32'(gnt0), 32'h1);
    chk("rstw first gnt1", 32'(gnt1), 32'h0);
    chk("rstw write count", 32'(wr_count - wc0), 32'h0);
    chk("rstw ram[0x80]",   ram[32], 32'h0);
    @(posedge clk_100M);
    #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk_100M);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
